// File: rtl/rob_param.sv
// Purpose : in-order reorder buffer; allocates tags at dispatch, takes CDB results, retires from the head.
// Latency : a CDB write is visible at commit and query one cycle later; flush takes effect on the next edge.
// Backpr. : alloc stalls while the buffer is full; commit holds while commit_ready is low.
module rob_param #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_req,
    input  logic [REG_W-1:0]  alloc_dest,
    input  logic              alloc_has_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic              commit_ready,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_dest,
    output logic              commit_has_dest,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    input  logic [TAG_W-1:0]  qry_tag,
    output logic              qry_hit,
    output logic [DATA_W-1:0] qry_data,
    output logic [TAG_W:0]    count
);

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              mispredict;
        logic              has_dest;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    entry_t           rob_q [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;

    entry_t head_ent;
    entry_t qry_ent;
    logic   alloc_fire;
    logic   commit_fire;
    logic   cdb_fire;

    assign head_ent = rob_q[head_q];
    assign qry_ent  = rob_q[qry_tag];

    // Full decode uses only the registered count, so a slot freed by commit is reusable next cycle.
    assign alloc_ready = (count_q != FULL_CNT);
    assign alloc_tag   = tail_q;
    assign count       = count_q;

    assign commit_valid    = head_ent.busy && head_ent.done;
    assign commit_tag      = head_q;
    assign commit_dest     = head_ent.dest;
    assign commit_has_dest = head_ent.has_dest;
    assign commit_data     = head_ent.data;

    assign commit_fire = commit_valid && commit_ready;
    assign flush       = commit_fire && head_ent.mispredict;
    // A mispredict retiring this cycle squashes any allocation made alongside it.
    assign alloc_fire  = alloc_req && alloc_ready && !flush;
    // Results for tags that are not in flight (e.g. squashed by a flush) are dropped.
    assign cdb_fire    = cdb_valid && rob_q[cdb_tag].busy;

    // Query reads registered state only; a same-cycle CDB result is not forwarded.
    assign qry_hit  = qry_ent.busy && qry_ent.done;
    assign qry_data = qry_ent.data;

    // Head/tail pointers and occupancy; wrap is implicit since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (commit_fire) begin
                head_q <= head_q + PTR_ONE;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Per-entry state: CDB completion, retirement and allocation never target the same live slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i].busy       <= 1'b0;
                rob_q[i].done       <= 1'b0;
                rob_q[i].mispredict <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_fire && (cdb_tag == TAG_W'(i))) begin
                    rob_q[i].done       <= 1'b1;
                    rob_q[i].data       <= cdb_data;
                    rob_q[i].mispredict <= cdb_mispredict;
                end
                if (commit_fire && (head_q == TAG_W'(i))) begin
                    rob_q[i].busy <= 1'b0;
                end
                if (alloc_fire && (tail_q == TAG_W'(i))) begin
                    rob_q[i].busy       <= 1'b1;
                    rob_q[i].done       <= 1'b0;
                    rob_q[i].mispredict <= 1'b0;
                    rob_q[i].dest       <= alloc_dest;
                    rob_q[i].has_dest   <= alloc_has_dest;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
module tb_rob_param;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int TAG_W  = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              alloc_req;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_has_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_mispredict;
    logic              commit_ready;
    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_dest;
    logic              commit_has_dest;
    logic [DATA_W-1:0] commit_data;
    logic              flush;
    logic [TAG_W-1:0]  qry_tag;
    logic              qry_hit;
    logic [DATA_W-1:0] qry_data;
    logic [TAG_W:0]    count;

    always #5 clk = ~clk;

    rob_param #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .alloc_req       (alloc_req),
        .alloc_dest      (alloc_dest),
        .alloc_has_dest  (alloc_has_dest),
        .alloc_ready     (alloc_ready),
        .alloc_tag       (alloc_tag),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .cdb_mispredict  (cdb_mispredict),
        .commit_ready    (commit_ready),
        .commit_valid    (commit_valid),
        .commit_tag      (commit_tag),
        .commit_dest     (commit_dest),
        .commit_has_dest (commit_has_dest),
        .commit_data     (commit_data),
        .flush           (flush),
        .qry_tag         (qry_tag),
        .qry_hit         (qry_hit),
        .qry_data        (qry_data),
        .count           (count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        alloc_req      = 1'b0;
        alloc_dest     = '0;
        alloc_has_dest = 1'b0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_data       = '0;
        cdb_mispredict = 1'b0;
        commit_ready   = 1'b0;
        qry_tag        = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #4;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            alloc_req      = 1'b1;
            alloc_dest     = 3'(i);
            alloc_has_dest = 1'b1;
            tick();
        end
        idle();
    endtask

    task automatic cdb_put(input logic [2:0] t, input logic [15:0] d, input logic m);
        idle();
        cdb_valid      = 1'b1;
        cdb_tag        = t;
        cdb_data       = d;
        cdb_mispredict = m;
        tick();
        idle();
    endtask

    // Table of single-cycle vectors: expected outputs are observed before the edge that applies the inputs.
    typedef struct {
        logic        a_req;
        logic        c_vld;
        logic [2:0]  c_tag;
        logic [15:0] c_dat;
        logic        c_rdy;
        logic        e_ready;
        logic [2:0]  e_tag;
        logic [3:0]  e_count;
        logic        e_cv;
        logic [15:0] e_cdata;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic cv, input logic [2:0] ct,
                                input logic [15:0] cd, input logic cr, input logic er,
                                input logic [2:0] et, input logic [3:0] ec,
                                input logic ecv, input logic [15:0] ecd);
        vec_t v;
        v.a_req = a;  v.c_vld = cv; v.c_tag = ct; v.c_dat = cd; v.c_rdy = cr;
        v.e_ready = er; v.e_tag = et; v.e_count = ec; v.e_cv = ecv; v.e_cdata = ecd;
        return v;
    endfunction

    // Behavioural reference: program-ordered list of in-flight tags plus per-tag result records.
    int          rq[$];
    bit          m_done [DEPTH];
    bit          m_misp [DEPTH];
    bit          m_hasd [DEPTH];
    logic [2:0]  m_dest [DEPTH];
    logic [15:0] m_data [DEPTH];
    int          m_next;

    function automatic bit live(input int t);
        foreach (rq[i]) if (rq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    vec_t vt[13];

    initial begin
        // Asynchronous reset before any clock edge
        idle();
        reset_n = 1'b0;
        #3;
        chk("reset count", count, 0);
        chk("reset alloc_ready", alloc_ready, 1);
        chk("reset alloc_tag", alloc_tag, 0);
        chk("reset commit_valid", commit_valid, 0);
        chk("reset flush", flush, 0);
        #4;
        reset_n = 1'b1;
        tick();

        // Fill, overflow attempt, then commit+alloc collision on a full buffer and wrap
        for (int i = 0; i < 8; i++) vt[i] = mk(1, 0, 0, 0, 0, 1, 3'(i), 4'(i), 0, 0);
        vt[8]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 8, 0, 0);
        vt[9]  = mk(0, 1, 0, 16'h0055, 0, 0, 0, 8, 0, 0);
        vt[10] = mk(1, 0, 0, 16'h0000, 1, 0, 0, 8, 1, 16'h0055);
        vt[11] = mk(1, 0, 0, 16'h0000, 0, 1, 0, 7, 0, 0);
        vt[12] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 8, 0, 0);
        for (int k = 0; k < 13; k++) begin
            idle();
            alloc_req      = vt[k].a_req;
            alloc_dest     = 3'(k);
            alloc_has_dest = 1'b1;
            cdb_valid      = vt[k].c_vld;
            cdb_tag        = vt[k].c_tag;
            cdb_data       = vt[k].c_dat;
            commit_ready   = vt[k].c_rdy;
            #1;
            chk($sformatf("vec%0d alloc_ready", k), alloc_ready, vt[k].e_ready);
            chk($sformatf("vec%0d alloc_tag", k), alloc_tag, vt[k].e_tag);
            chk($sformatf("vec%0d count", k), count, vt[k].e_count);
            chk($sformatf("vec%0d commit_valid", k), commit_valid, vt[k].e_cv);
            if (vt[k].e_cv) chk($sformatf("vec%0d commit_data", k), commit_data, vt[k].e_cdata);
            tick();
        end

        // Out-of-order completion, in-order retirement
        do_reset();
        alloc_n(2);
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h1234; commit_ready = 1'b1;
        #1;
        chk("order cv before any cdb", commit_valid, 0);
        tick();
        idle();
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h00AA; commit_ready = 1'b1;
        #1;
        chk("order cv tag1 done only", commit_valid, 0);
        tick();
        idle();
        commit_ready = 1'b1;
        #1;
        chk("order first cv", commit_valid, 1);
        chk("order first tag", commit_tag, 0);
        chk("order first data", commit_data, 16'h00AA);
        tick();
        chk("order second cv", commit_valid, 1);
        chk("order second tag", commit_tag, 1);
        chk("order second data", commit_data, 16'h1234);
        tick();
        idle();
        #1;
        chk("order drained cv", commit_valid, 0);
        chk("order drained count", count, 0);

        // Mispredict flush
        do_reset();
        alloc_n(4);
        cdb_put(3'd0, 16'h0077, 1'b1);
        commit_ready = 1'b1;
        alloc_req    = 1'b1;
        #1;
        chk("flush commit_valid", commit_valid, 1);
        chk("flush asserted", flush, 1);
        chk("flush count before", count, 4);
        tick();
        idle();
        #1;
        chk("flush deasserted", flush, 0);
        chk("flush count after", count, 0);
        chk("flush alloc_tag after", alloc_tag, 0);
        chk("flush cv after", commit_valid, 0);
        cdb_put(3'd2, 16'h2222, 1'b0);
        qry_tag = 3'd2;
        #1;
        chk("flush stale cdb qry_hit", qry_hit, 0);
        chk("flush stale cdb count", count, 0);
        idle();
        alloc_req = 1'b1;
        #1;
        chk("flush realloc tag", alloc_tag, 0);
        tick();
        idle();
        #1;
        chk("flush realloc count", count, 1);
        chk("flush realloc cv", commit_valid, 0);

        // Operand query
        do_reset();
        alloc_n(6);
        cdb_put(3'd5, 16'hBEEF, 1'b0);
        qry_tag = 3'd5;
        #1;
        chk("qry done hit", qry_hit, 1);
        chk("qry done data", qry_data, 16'hBEEF);
        qry_tag   = 3'd3;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h3333;
        #1;
        chk("qry same-cycle cdb hit", qry_hit, 0);
        tick();
        idle();
        qry_tag = 3'd3;
        #1;
        chk("qry next-cycle hit", qry_hit, 1);
        chk("qry next-cycle data", qry_data, 16'h3333);
        qry_tag = 3'd6;
        #1;
        chk("qry free slot hit", qry_hit, 0);

        // Mid-cycle asynchronous reset with live entries
        do_reset();
        alloc_n(4);
        cdb_put(3'd0, 16'h0001, 1'b0);
        #1;
        chk("areset pre count", count, 4);
        chk("areset pre cv", commit_valid, 1);
        commit_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset count", count, 0);
        chk("areset alloc_ready", alloc_ready, 1);
        chk("areset alloc_tag", alloc_tag, 0);
        chk("areset commit_valid", commit_valid, 0);
        chk("areset flush", flush, 0);
        #1;
        reset_n = 1'b1;
        tick();
        idle();
        alloc_req = 1'b1;
        #1;
        chk("areset first tag", alloc_tag, 0);
        chk("areset release count", count, 0);
        tick();
        idle();
        #1;
        chk("areset alloc count", count, 1);

        // Randomized traffic against the reference model
        do_reset();
        rq.delete();
        m_next = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit e_cv, e_flush, e_hit, do_commit;
            int old_size;
            idle();
            alloc_req      = ($urandom_range(0, 9) < 6);
            alloc_dest     = 3'($urandom);
            alloc_has_dest = 1'($urandom);
            cdb_valid      = 1'($urandom);
            if (rq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = 3'(rq[$urandom_range(0, rq.size() - 1)]);
            else
                cdb_tag = 3'($urandom);
            cdb_data       = 16'($urandom);
            cdb_mispredict = ($urandom_range(0, 24) == 0);
            commit_ready   = ($urandom_range(0, 9) < 7);
            qry_tag        = 3'($urandom);
            #1;
            old_size  = rq.size();
            e_cv      = (old_size > 0) && m_done[rq[0]];
            do_commit = e_cv && commit_ready;
            e_flush   = do_commit && m_misp[rq[0]];
            e_hit     = live(int'(qry_tag)) && m_done[qry_tag];
            chk("rnd alloc_ready", alloc_ready, (old_size != DEPTH));
            chk("rnd alloc_tag", alloc_tag, m_next);
            chk("rnd count", count, old_size);
            chk("rnd commit_valid", commit_valid, e_cv);
            chk("rnd flush", flush, e_flush);
            if (e_cv) begin
                chk("rnd commit_tag", commit_tag, rq[0]);
                chk("rnd commit_dest", commit_dest, m_dest[rq[0]]);
                chk("rnd commit_has_dest", commit_has_dest, m_hasd[rq[0]]);
                chk("rnd commit_data", commit_data, m_data[rq[0]]);
            end
            chk("rnd qry_hit", qry_hit, e_hit);
            if (e_hit) chk("rnd qry_data", qry_data, m_data[qry_tag]);

            if (cdb_valid && live(int'(cdb_tag))) begin
                m_done[cdb_tag] = 1'b1;
                m_data[cdb_tag] = cdb_data;
                m_misp[cdb_tag] = cdb_mispredict;
            end
            if (e_flush) begin
                rq.delete();
                m_next = 0;
            end else begin
                if (do_commit) void'(rq.pop_front());
                if (alloc_req && old_size != DEPTH) begin
                    rq.push_back(m_next);
                    m_done[m_next] = 1'b0;
                    m_misp[m_next] = 1'b0;
                    m_dest[m_next] = alloc_dest;
                    m_hasd[m_next] = alloc_has_dest;
                    m_next = (m_next + 1) % DEPTH;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 Parameter DEPTH, default 8, number of ROB entries; power of two, at least 2.
REQ-002 Parameter DATA_W, default 16, result data width.
REQ-003 Parameter REG_W, default 3, architectural register index width.
REQ-004 Parameter TAG_W, default $clog2(DEPTH), ROB tag width, i.e. 3 at defaults.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_req  in  1  dispatch requests one entry.
- alloc_dest  in  REG_W  destination register of the allocated instruction.
- alloc_has_dest  in  1  instruction writes a register.
- alloc_ready  out  1  entry available (not full).
- alloc_tag  out  TAG_W  tag granted to the request (current tail).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB broadcast tag.
- cdb_data  in  DATA_W  CDB broadcast result.
- cdb_mispredict  in  1  broadcast instruction was a mispredicted branch.
- commit_ready  in  1  register file accepts a commit this cycle.
- commit_valid  out  1  head entry done and presented.
- commit_tag  out  TAG_W  head tag.
- commit_dest  out  REG_W  head destination register.
- commit_has_dest  out  1  head writes a register.
- commit_data  out  DATA_W  head result.
- flush  out  1  mispredicted head committed this cycle.
- qry_tag  in  TAG_W  operand lookup tag.
- qry_hit  out  1  queried entry busy and done.
- qry_data  out  DATA_W  queried entry result.
- count  out  TAG_W+1  occupied entries.

Function
REQ-006 Circular buffer with head pointer, tail pointer and count register; each entry holds busy, done, mispredict, has_dest, dest and data.
REQ-007 alloc_ready = (count != DEPTH), decoded from registered count only; no same-cycle reuse of a slot freed by commit.
REQ-008 alloc fire = alloc_req && alloc_ready && !flush. On fire: entry[tail] gets busy=1, done=0, mispredict=0, dest/has_dest loaded; tail advances by 1 modulo DEPTH.
REQ-009 A CDB write (cdb_valid && entry[cdb_tag].busy) sets done=1, data=cdb_data and mispredict=cdb_mispredict. A CDB write to a non-busy entry is ignored.
REQ-010 commit_valid = entry[head].busy && entry[head].done, from registered state. A CDB write to the head is therefore visible at commit the following cycle.
REQ-011 commit fire = commit_valid && commit_ready. On fire: entry[head].busy clears and head advances modulo DEPTH.
REQ-012 Count update: +1 on alloc only, -1 on commit only, unchanged when both occur.
REQ-013 flush = commit fire && entry[head].mispredict, combinational. On the next edge all busy/done bits clear, head=tail=0, count=0, and any same-cycle alloc is dropped.
REQ-014 Query path is combinational: qry_hit = entry[qry_tag].busy && done; qry_data = entry[qry_tag].data. It does not observe same-cycle CDB data.
REQ-015 Pointers wrap from DEPTH-1 to 0 with no lost or duplicated tags.
REQ-016 With commit_valid=0, the commit_* data outputs reflect the head entry but carry no meaning.

Reset
REQ-017 reset_n low immediately clears, independent of clk: head, tail, count=0, all busy/done/mispredict bits=0, commit_valid=0, flush=0, alloc_ready=1, alloc_tag=0.
REQ-018 reset_n asserted mid-operation discards all entries; the first alloc after release receives tag 0.

Verification
REQ-019 Reset, then 8 allocs with no CDB -> tags 0..7 granted, count=8, alloc_ready=0; a 9th alloc_req is ignored.
REQ-020 Allocate tags 0,1; CDB tag1 data 16'h1234, then tag0 data 16'h00AA; commit_ready=1 -> commits in order tag0 (00AA) then tag1 (1234), each one cycle after its CDB at earliest.
REQ-021 Full ROB, head done, alloc_req and commit_ready in the same cycle -> commit only; count=7; alloc succeeds on the next cycle with tag 0 (wrap).
REQ-022 Allocate tags 0..3; CDB tag0 mispredict=1; commit -> flush=1 for one cycle; next cycle count=0, alloc_tag=0; a CDB to old tag 2 is ignored.
REQ-023 Tag 5 done with 16'hBEEF -> qry_tag=5 gives qry_hit=1, qry_data=BEEF; qry_tag of a busy, not-done entry gives qry_hit=0.
REQ-024 Assert reset_n low between clock edges with 4 entries live -> outputs reach reset values before the next edge; after release, count=0.
